// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit for a single-memory-port RISC-V datapath.
// Define ILLEGAL_TRAP_EN to send illegal decodes to a sticky TRAP state; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [6:0]         funct7,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               pc_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               mem2reg,
  output logic               alu_src,
  output logic               mem_write,
  output logic               mem_read,
  output logic [3:0]         alu_cc,
  output logic               instr_done,
  output logic [COUNT_W-1:0] retired_count,
  output logic [2:0]         state_dbg
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_NONE    = 3'd0,
    C_RTYPE   = 3'd1,
    C_ITYPE   = 3'd2,
    C_LOAD    = 3'd3,
    C_STORE   = 3'd4,
    C_ILLEGAL = 3'd5
  } class_t;

  state_t     state, state_next;
  class_t     cls_q, dec_class;
  logic [3:0] cc_q, dec_cc;
  logic [4:0] arith;
  logic       quiet;
  logic       nop_pend;

  // {valid, alu_cc} for the funct3 codes shared by register and immediate arithmetic
  function automatic logic [4:0] arith_cc(input logic [2:0] f3);
    case (f3)
      3'b000:  arith_cc = {1'b1, 4'b0010};
      3'b100:  arith_cc = {1'b1, 4'b1100};
      3'b110:  arith_cc = {1'b1, 4'b0001};
      3'b111:  arith_cc = {1'b1, 4'b0000};
      3'b010:  arith_cc = {1'b1, 4'b0111};
      default: arith_cc = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    arith     = arith_cc(funct3);
    dec_class = C_ILLEGAL;
    dec_cc    = 4'b0000;
    case (opcode)
      OP_RTYPE: begin
        if (funct7 == 7'b0000000 && arith[4]) begin
          dec_class = C_RTYPE;
          dec_cc    = arith[3:0];
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          dec_class = C_RTYPE;
          dec_cc    = 4'b0110;
        end
      end
      OP_ITYPE: begin
        if (arith[4]) begin
          dec_class = C_ITYPE;
          dec_cc    = arith[3:0];
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          dec_class = C_LOAD;
          dec_cc    = 4'b0010;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          dec_class = C_STORE;
          dec_cc    = 4'b0010;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FETCH;
      cls_q         <= C_NONE;
      cc_q          <= 4'b0000;
      quiet         <= 1'b1;
      nop_pend      <= 1'b0;
      retired_count <= '0;
    end else begin
      state    <= state_next;
      quiet    <= 1'b0;
      nop_pend <= !TRAP_EN && (state == S_DECODE) && (dec_class == C_ILLEGAL);
      if (state == S_DECODE) begin
        cls_q <= dec_class;
        cc_q  <= dec_cc;
      end
      if (instr_done) retired_count <= retired_count + COUNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  if (!quiet && imem_ready) state_next = S_DECODE;
      S_DECODE: begin
        if (dec_class == C_ILLEGAL) state_next = TRAP_EN ? S_TRAP : S_FETCH;
        else                        state_next = S_EXEC;
      end
      S_EXEC:   state_next = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
      S_MEM:    if (dmem_ready) state_next = (cls_q == C_LOAD) ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_FETCH;
    endcase
  end

  // Strobes are quiet during reset and for the one FETCH cycle that follows it.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem2reg    = 1'b0;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_cc     = 4'b0000;
    instr_done = nop_pend;
    case (state)
      S_FETCH: begin
        if (!quiet) begin
          mem_read = 1'b1;
          ir_write = imem_ready;
          pc_write = imem_ready;
        end
      end
      S_EXEC: begin
        alu_cc  = cc_q;
        alu_src = (cls_q != C_RTYPE);
      end
      S_MEM: begin
        alu_cc    = cc_q;
        alu_src   = 1'b1;
        mem_read  = (cls_q == C_LOAD);
        mem_write = (cls_q == C_STORE);
        if (cls_q == C_STORE && dmem_ready) instr_done = 1'b1;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem2reg    = (cls_q == C_LOAD);
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem2reg    = 1'b0;
      alu_src    = 1'b0;
      mem_write  = 1'b0;
      mem_read   = 1'b0;
      alu_cc     = 4'b0000;
      instr_done = 1'b0;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: per-instruction cycle scripts expanded from the ISA rules, checked every cycle.
// Honours ILLEGAL_TRAP_EN the same way as the design.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        pc_write, ir_write, reg_write, mem2reg, alu_src, mem_write, mem_read, instr_done;
  logic [3:0]  alu_cc;
  logic [15:0] retired_count;
  logic [2:0]  state_dbg;
  logic        pc_write_2, ir_write_2, reg_write_2, mem2reg_2, alu_src_2, mem_write_2, mem_read_2, instr_done_2;
  logic [3:0]  alu_cc_2;
  logic [1:0]  retired_count_2;
  logic [2:0]  state_dbg_2;

  always #5 clk = ~clk;

  multicycle_ctrl #(.COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write), .mem2reg(mem2reg),
    .alu_src(alu_src), .mem_write(mem_write), .mem_read(mem_read), .alu_cc(alu_cc),
    .instr_done(instr_done), .retired_count(retired_count), .state_dbg(state_dbg)
  );

  multicycle_ctrl #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(pc_write_2), .ir_write(ir_write_2), .reg_write(reg_write_2), .mem2reg(mem2reg_2),
    .alu_src(alu_src_2), .mem_write(mem_write_2), .mem_read(mem_read_2), .alu_cc(alu_cc_2),
    .instr_done(instr_done_2), .retired_count(retired_count_2), .state_dbg(state_dbg_2)
  );

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int CL_R = 0, CL_I = 1, CL_L = 2, CL_S = 3, CL_X = 4;
  localparam logic [6:0] OPR = 7'b0110011, OPI = 7'b0010011, OPL = 7'b0000011, OPS = 7'b0100011;

  typedef struct {
    bit         rst, ir, dr, nop, chk_state;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [2:0] st;
    bit         pcw, irw, rw, m2r, asrc, mw, mr, done;
    logic [3:0] cc;
  } rec_t;

  rec_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_cnt = 0;
  bit   nop_pending = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic void model_decode(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                       output int cls, output logic [3:0] cc);
    logic [3:0] ar;
    bit ok;
    ok = 1;
    case (f3)
      3'd0: ar = 4'b0010;
      3'd4: ar = 4'b1100;
      3'd6: ar = 4'b0001;
      3'd7: ar = 4'b0000;
      3'd2: ar = 4'b0111;
      default: begin ar = 4'b0000; ok = 0; end
    endcase
    cls = CL_X;
    cc  = 4'b0000;
    if (op == OPR) begin
      if (f7 == 7'd0 && ok) begin cls = CL_R; cc = ar; end
      else if (f7 == 7'b0100000 && f3 == 3'd0) begin cls = CL_R; cc = 4'b0110; end
    end else if (op == OPI) begin
      if (ok) begin cls = CL_I; cc = ar; end
    end else if ((op == OPL || op == OPS) && f3 == 3'b010) begin
      cls = (op == OPS) ? CL_S : CL_L;
      cc  = 4'b0010;
    end
  endfunction

  // A cycle with don't-care inputs randomised and every strobe expected low.
  function automatic rec_t blank(input logic [2:0] st);
    rec_t r;
    r.rst = 0; r.nop = 0; r.chk_state = 1; r.st = st;
    r.ir = 1'($urandom); r.dr = 1'($urandom);
    r.op = 7'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
    r.pcw = 0; r.irw = 0; r.rw = 0; r.m2r = 0; r.asrc = 0; r.mw = 0; r.mr = 0; r.done = 0;
    r.cc = 4'b0000;
    return r;
  endfunction

  function automatic void add(input rec_t r);
    rec_t t;
    t = r;
    if (t.rst) nop_pending = 0;
    else if (nop_pending) begin t.done = 1; nop_pending = 0; end
    if (t.nop) nop_pending = 1;
    q.push_back(t);
  endfunction

  function automatic void gen_reset(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = blank(3'd0); r.rst = 1; r.chk_state = 0;
      add(r);
    end
    add(blank(3'd0));
  endfunction

  function automatic void gen_idle(input int n);
    rec_t r;
    for (int i = 0; i < n; i++) begin
      r = blank(3'd0); r.ir = 0; r.mr = 1;
      add(r);
    end
  endfunction

  // Expand one instruction into its expected cycles; cut>0 keeps only the first cut cycles.
  function automatic void gen_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                    input int ni, input int nd, input int cut, output int len);
    rec_t lq[$];
    rec_t r;
    int cls;
    logic [3:0] cc;
    model_decode(op, f3, f7, cls, cc);
    for (int i = 0; i < ni; i++) begin
      r = blank(3'd0); r.ir = 0; r.mr = 1; lq.push_back(r);
    end
    r = blank(3'd0); r.ir = 1; r.mr = 1; r.irw = 1; r.pcw = 1; lq.push_back(r);
    r = blank(3'd1); r.op = op; r.f3 = f3; r.f7 = f7; r.nop = (cls == CL_X && !TRAP); lq.push_back(r);
    if (cls == CL_X) begin
      if (TRAP) for (int i = 0; i < 4; i++) lq.push_back(blank(3'd5));
    end else begin
      r = blank(3'd2); r.cc = cc; r.asrc = (cls != CL_R); lq.push_back(r);
      if (cls == CL_L || cls == CL_S) begin
        for (int j = 0; j <= nd; j++) begin
          r = blank(3'd3); r.cc = cc; r.asrc = 1; r.dr = (j == nd);
          r.mr = (cls == CL_L); r.mw = (cls == CL_S); r.done = (cls == CL_S && j == nd);
          lq.push_back(r);
        end
      end
      if (cls != CL_S) begin
        r = blank(3'd4); r.rw = 1; r.m2r = (cls == CL_L); r.done = 1; lq.push_back(r);
      end
    end
    len = lq.size();
    foreach (lq[i]) if (cut == 0 || i < cut) add(lq[i]);
  endfunction

  task automatic run_q();
    rec_t r;
    while (q.size() > 0) begin
      r = q.pop_front();
      @(posedge clk); #1;
      rst = r.rst; imem_ready = r.ir; dmem_ready = r.dr;
      opcode = r.op; funct3 = r.f3; funct7 = r.f7;
      @(negedge clk);
      chk("pc_write",   32'(pc_write),   32'(r.pcw));
      chk("ir_write",   32'(ir_write),   32'(r.irw));
      chk("reg_write",  32'(reg_write),  32'(r.rw));
      chk("mem2reg",    32'(mem2reg),    32'(r.m2r));
      chk("alu_src",    32'(alu_src),    32'(r.asrc));
      chk("mem_write",  32'(mem_write),  32'(r.mw));
      chk("mem_read",   32'(mem_read),   32'(r.mr));
      chk("alu_cc",     32'(alu_cc),     32'(r.cc));
      chk("instr_done", 32'(instr_done), 32'(r.done));
      chk("retired_count",   32'(retired_count),   32'(model_cnt & 16'hFFFF));
      chk("retired_count_w2", 32'(retired_count_2), 32'(model_cnt & 3));
      if (r.chk_state) chk("state_dbg", 32'(state_dbg), 32'(r.st));
      if (r.rst) model_cnt = 0;
      else if (r.done) model_cnt++;
    end
  endtask

  initial begin
    int len, cls, cut;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] cc;
    repeat (3) @(posedge clk);

    gen_reset(2);
    run_q();
    chk("reset_count", 32'(retired_count), 32'd0);

    gen_instr(OPL, 3'b010, 7'd0, 0, 5, 5, len);
    gen_reset(2);
    run_q();
    chk("mid_mem_reset_count", 32'(retired_count), 32'd0);

    gen_instr(OPR, 3'b000, 7'b0100000, 0, 0, 0, len);
    chk("len_sub", 32'(len), 32'd4);
    gen_idle(1); run_q();
    chk("count_after_sub", 32'(retired_count), 32'd1);

    gen_instr(OPL, 3'b010, 7'd0, 0, 3, 0, len);
    chk("len_load_3stall", 32'(len), 32'd8);
    gen_idle(1); run_q();
    chk("count_after_load", 32'(retired_count), 32'd2);

    gen_instr(OPS, 3'b010, 7'd0, 0, 0, 0, len);
    chk("len_store", 32'(len), 32'd4);
    gen_idle(1); run_q();
    chk("count_after_store", 32'(retired_count), 32'd3);

    gen_instr(OPI, 3'b100, 7'b0100000, 0, 0, 0, len);
    chk("len_xori", 32'(len), 32'd4);
    gen_idle(1); run_q();
    chk("count_after_xori", 32'(retired_count), 32'd4);

    gen_instr(7'b1111111, 3'b000, 7'd0, 0, 0, 0, len);
    if (TRAP) begin
      chk("len_illegal_trap", 32'(len), 32'd6);
      run_q();
      chk("trap_state", 32'(state_dbg), 32'd5);
      chk("trap_count", 32'(retired_count), 32'd4);
      chk("trap_count_w2", 32'(retired_count_2), 32'd0);
      gen_reset(1);
    end else begin
      chk("len_illegal_nop", 32'(len), 32'd2);
      gen_idle(2); run_q();
      chk("nop_count", 32'(retired_count), 32'd5);
      chk("wrap_count_w2", 32'(retired_count_2), 32'd1);
    end
    run_q();

    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 4))
        0: op = OPR;
        1: op = OPI;
        2: op = OPL;
        3: op = OPS;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom_range(0, 7));
      if ((op == OPL || op == OPS) && $urandom_range(0, 3) != 0) f3 = 3'b010;
      if ($urandom_range(0, 2) == 0) f7 = 7'($urandom);
      else f7 = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'd0;
      cut = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
      gen_instr(op, f3, f7, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), cut, len);
      model_decode(op, f3, f7, cls, cc);
      if (cut != 0 || (TRAP && cls == CL_X)) gen_reset(int'($urandom_range(1, 2)));
      run_q();
    end
    gen_idle(2);
    run_q();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
